// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial external memory controller for fetch and load/store traffic
// MEM_CTRL_RR_EN selects round-robin arbitration instead of fixed data-over-instruction priority.
module mem_ctrl #(
    parameter int IO_TAG_LSB = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        inst_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_res,
    input  logic        data_valid,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_value,
    output logic        data_ready,
    output logic [31:0] data_res
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] word_q;
    logic [1:0]  last_idx;
    logic [1:0]  ai;
    logic [1:0]  ci;
    logic [1:0]  ai_nxt;
    logic        drv;
    logic        pend;
    logic        paused;
    logic        zext;
    logic        is_inst;
    logic        io_req;
    logic        wr_q;
    logic        accept;
    logic        grant_data;
    logic [31:0] rd_word;
    logic [31:0] load_ext;

    assign accept = (state == IDLE) && rdy_in && !clear && (inst_valid || data_valid);
    assign ai_nxt = ai + 2'd1;
    assign mem_wr = wr_q && rdy_in && !(io_req && io_buffer_full);

`ifdef MEM_CTRL_RR_EN
    logic prio_data;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            prio_data <= 1'b1;
        else if (accept)
            prio_data <= !grant_data;
    end

    assign grant_data = data_valid && (prio_data || !inst_valid);
`else
    assign grant_data = data_valid;
`endif

    // Word as it will look once the byte on mem_din this cycle is captured.
    always_comb begin
        rd_word = word_q;
        rd_word[{ci, 3'b000} +: 8] = mem_din;
        case (last_idx)
            2'd0:    load_ext = zext ? {24'h0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
            2'd1:    load_ext = zext ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            mem_a      <= 32'h0;
            mem_dout   <= 8'h0;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            inst_res   <= 32'h0;
            data_res   <= 32'h0;
            base       <= 32'h0;
            word_q     <= 32'h0;
            last_idx   <= 2'd0;
            ai         <= 2'd0;
            ci         <= 2'd0;
            drv        <= 1'b0;
            pend       <= 1'b0;
            paused     <= 1'b0;
            zext       <= 1'b0;
            is_inst    <= 1'b0;
            io_req     <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            // Remembers a pause so the first live edge can restart the read stream.
            paused <= !rdy_in;
            if (rdy_in) begin
                case (state)
                    IDLE: begin
                        inst_ready <= 1'b0;
                        data_ready <= 1'b0;
                        if (accept) begin
                            ai   <= 2'd0;
                            ci   <= 2'd0;
                            pend <= 1'b0;
                            if (grant_data) begin
                                base     <= data_addr;
                                mem_a    <= data_addr;
                                last_idx <= {data_size[1], data_size[1] | data_size[0]};
                                zext     <= data_size[2];
                                is_inst  <= 1'b0;
                                io_req   <= data_wr && (data_addr[IO_TAG_LSB +: 2] == 2'b11);
                                if (data_wr) begin
                                    state    <= WRITE;
                                    word_q   <= data_value;
                                    mem_dout <= data_value[7:0];
                                    wr_q     <= 1'b1;
                                end else begin
                                    state <= READ;
                                    drv   <= 1'b1;
                                end
                            end else begin
                                base     <= inst_addr;
                                mem_a    <= inst_addr;
                                last_idx <= 2'd3;
                                zext     <= 1'b0;
                                is_inst  <= 1'b1;
                                io_req   <= 1'b0;
                                state    <= READ;
                                drv      <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (clear) begin
                            state <= IDLE;
                            mem_a <= 32'h0;
                            drv   <= 1'b0;
                            pend  <= 1'b0;
                        end else if (paused) begin
                            // Returns during the pause were lost; re-issue from the oldest missing byte.
                            mem_a <= base + {30'h0, ci};
                            ai    <= ci;
                            drv   <= 1'b1;
                            pend  <= 1'b0;
                        end else begin
                            pend <= drv;
                            if (drv) begin
                                if (ai == last_idx) begin
                                    drv <= 1'b0;
                                end else begin
                                    ai    <= ai_nxt;
                                    mem_a <= base + {30'h0, ai_nxt};
                                end
                            end
                            if (pend) begin
                                word_q[{ci, 3'b000} +: 8] <= mem_din;
                                ci <= ci + 2'd1;
                                if (ci == last_idx) begin
                                    state <= DONE;
                                    mem_a <= 32'h0;
                                    if (is_inst) begin
                                        inst_ready <= 1'b1;
                                        inst_res   <= rd_word;
                                    end else begin
                                        data_ready <= 1'b1;
                                        data_res   <= load_ext;
                                    end
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (mem_wr) begin
                            if (ai == last_idx) begin
                                state      <= DONE;
                                wr_q       <= 1'b0;
                                mem_a      <= 32'h0;
                                mem_dout   <= 8'h0;
                                data_ready <= 1'b1;
                            end else begin
                                ai       <= ai_nxt;
                                mem_a    <= base + {30'h0, ai_nxt};
                                mem_dout <= word_q[{ai_nxt, 3'b000} +: 8];
                            end
                        end
                    end
                    DONE: begin
                        inst_ready <= 1'b0;
                        data_ready <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the byte-wide external memory bus (mem_din/mem_dout/mem_a/mem_wr).
- Arbitrates between the instruction fetcher (always 32-bit reads) and the load/store buffer (1/2/4-byte reads and writes).
- Sequences each multi-byte access as consecutive single-byte bus cycles, little-endian.
- Handles UART back-pressure on I/O writes, ROB flush, and rdy_in pause.

Parameters:
IO_TAG_LSB, 16, LSB of the 2-bit I/O tag in the address; address is I/O when addr[IO_TAG_LSB+1:IO_TAG_LSB]==2'b11

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  low = freeze all state
clear  in  1  ROB flush, one-cycle pulse
mem_din  in  8  read byte, returned one cycle after its address
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART TX buffer full
inst_valid  in  1  fetch request, held until inst_ready
inst_addr  in  32  fetch address
inst_ready  out  1  one-cycle pulse, inst_res valid
inst_res  out  32  fetched word
data_valid  in  1  data request, held until data_ready
data_wr  in  1  1 = store
data_size  in  3  [1:0] = log2(bytes) (0/1/2); [2] = 1 zero-extend, 0 sign-extend (loads only)
data_addr  in  32  byte address
data_value  in  32  store data, low bytes used
data_ready  out  1  one-cycle pulse, load result valid / store done
data_res  out  32  extended load result

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, inst_ready=0, data_ready=0, inst_res=0, data_res=0, grant pointer = data.
- In IDLE, mem_wr=0 and mem_a=0.
- FSM states:
  - IDLE: samples requests on a clock edge; goes to READ or WRITE.
  - READ: N bytes (N=4 for fetch). Byte i address is driven during cycle A+i, where A is the first cycle after acceptance. Byte i is captured from mem_din at the end of cycle A+i+1.
  - DONE: ready pulse high for exactly one cycle, in cycle A+N+1; returns to IDLE.
  - WRITE: byte i is driven with mem_wr=1 during cycle A+i; data_ready pulses in cycle A+N; returns to IDLE.
- Requests are not re-sampled in the cycle their ready is high. At least one IDLE cycle follows every ready.
- Requesters hold valid and all fields stable until ready.
- Load extension: N=1 or 2 with size[2]=0 sign-extends from bit 8N-1; size[2]=1 zero-extends.
- Fixed priority (default): data wins when both valid in IDLE.
- I/O write (I/O tag set): before driving each byte, wait while io_buffer_full=1. While waiting, mem_wr=0 and the byte counter holds.
- clear, in any cycle:
  - Aborts an in-progress instruction read or data read: no ready is pulsed, next state IDLE. A byte returning after the abort is discarded.
  - Does not abort an in-progress write; the write completes and data_ready still pulses.
  - A request sampled in the same cycle as clear is ignored.
- rdy_in low:
  - All registers hold and mem_wr is forced 0 (combinationally gated).
  - On resume, a READ re-presents the address of the oldest uncaptured byte. Bytes whose return cycle fell in a paused cycle are re-read.
  - Counters never skip a byte.
- Address arithmetic: byte i address = base + i, 32-bit, wrap ignored (no access crosses 0xFFFFFFFF).
- data_size[1:0]=3 is illegal; behaviour undefined, no assertion is required.

Optional Feature:
MEM_CTRL_RR_EN
- Defined: round-robin arbitration. On simultaneous valid in IDLE, grant goes to the requester not granted last; the grant pointer updates on each acceptance. A lone requester is always granted.
- Undefined: fixed data-over-instruction priority; no grant pointer is instantiated.

Test Plan:
- Word load at 0x100, memory bytes 0x78,0x56,0x34,0x12 -> mem_a sequence 0x100..0x103 on consecutive cycles; data_ready one cycle, 6 cycles after acceptance edge; data_res=0x12345678.
- LB at 0x200 holding 0x80 -> data_res=0xFFFFFF80; LBU same address -> 0x00000080; LH of 0x8001 with size[2]=0 -> 0xFFFF8001.
- inst_valid and data_valid both high in IDLE, repeated 4 times:
  - Default: data granted every contested cycle.
  - With MEM_CTRL_RR_EN: grants alternate data, inst, data, inst.
- SB 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then exactly one cycle mem_wr=1, mem_a=0x30000, mem_dout=0x41; data_ready next cycle.
- clear asserted during byte 2 of a fetch at 0x1000 -> inst_ready never pulses; IDLE next cycle; a new fetch at 0x2000 returns the correct word. clear during byte 1 of SW 0xAABBCCDD -> all 4 bytes written, data_ready pulses.
- rdy_in low for 2 cycles mid word load -> no counter advance and mem_wr=0 while low; data_res still exact (0x12345678) with latency extended by the pause plus the re-read.
